// File: rtl/fd_delay_line_pkg.sv
// Shared types and helpers for the MC100EP195 delay-line loader.
// Holds the FSM state type, the tap width and the round-robin search function.
package fd_delay_line_pkg;

    localparam int c_FD_TAP_WIDTH = 10;
    localparam int c_MAX_CHANNELS = 16;
    localparam int c_IDX_W        = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } t_loader_state;

    typedef struct packed {
        logic               valid;
        logic [c_IDX_W-1:0] idx;
    } t_rr_sel;

    // First set request at or above ptr, wrapping at num.
    // The scan runs downward so the nearest candidate is written last and wins.
    function automatic t_rr_sel f_rr_select(input logic [c_MAX_CHANNELS-1:0] req,
                                            input logic [c_IDX_W-1:0]        ptr,
                                            input int                        num);
        t_rr_sel            r;
        int                 pos;
        logic [c_IDX_W-1:0] p;
        r = '0;
        for (int k = c_MAX_CHANNELS - 1; k >= 0; k--) begin
            if (k < num) begin
                pos = int'(ptr) + k;
                if (pos >= num) pos = pos - num;
                p = c_IDX_W'(pos);
                if (req[p]) begin
                    r.valid = 1'b1;
                    r.idx   = p;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fd_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus binary index.
// The pointer register lives in the loader.
import fd_delay_line_pkg::*;

module fd_rr_arbiter #(
    parameter int g_NUM_CHANNELS = 8
) (
    input  logic [g_NUM_CHANNELS-1:0] req,
    input  logic [c_IDX_W-1:0]        ptr,
    output logic [g_NUM_CHANNELS-1:0] grant,
    output logic [c_IDX_W-1:0]        idx,
    output logic                      valid
);

    logic [c_MAX_CHANNELS-1:0] req_ext;
    t_rr_sel                   sel;

    always_comb begin
        req_ext = '0;
        req_ext[g_NUM_CHANNELS-1:0] = req;
        sel   = f_rr_select(req_ext, ptr, g_NUM_CHANNELS);
        grant = '0;
        for (int i = 0; i < g_NUM_CHANNELS; i++)
            grant[i] = sel.valid && (sel.idx == c_IDX_W'(i));
    end

    assign idx   = sel.idx;
    assign valid = sel.valid;

endmodule

// File: rtl/fd_delay_line_loader.sv
// Programs the shared-bus MC100EP195 delay lines one channel at a time:
// tap bus setup, per-chip LEN strobe, hold, then a one-cycle ack.
import fd_delay_line_pkg::*;

module fd_delay_line_loader #(
    parameter int g_NUM_CHANNELS = 8,
    parameter int g_SETUP_CYCLES = 2,
    parameter int g_LEN_CYCLES   = 3,
    parameter int g_HOLD_CYCLES  = 2
) (
    input  logic                                     clk_sys_i,
    input  logic                                     rst_sys_i,
    input  logic [g_NUM_CHANNELS-1:0]                req_i,
    input  logic [c_FD_TAP_WIDTH*g_NUM_CHANNELS-1:0] dly_i,
    output logic [g_NUM_CHANNELS-1:0]                ack_o,
    output logic [c_FD_TAP_WIDTH-1:0]                dly_o,
    output logic [g_NUM_CHANNELS-1:0]                len_o,
    output logic                                     busy_o,
    output logic [c_FD_TAP_WIDTH*g_NUM_CHANNELS-1:0] cur_dly_o
);

    localparam int c_TW = c_FD_TAP_WIDTH;

    t_loader_state               state;
    logic [7:0]                  cnt;
    logic [c_IDX_W-1:0]          rr_ptr;
    logic [c_IDX_W-1:0]          sel;
    logic [g_NUM_CHANNELS-1:0]   sel_oh;
    logic [g_NUM_CHANNELS-1:0]   arb_grant;
    logic [c_IDX_W-1:0]          arb_idx;
    logic                        arb_valid;
    logic [c_TW-1:0]             arb_dly;

    fd_rr_arbiter #(
        .g_NUM_CHANNELS(g_NUM_CHANNELS)
    ) u_arb (
        .req   (req_i),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        arb_dly = '0;
        for (int i = 0; i < g_NUM_CHANNELS; i++)
            if (arb_grant[i]) arb_dly = arb_dly | dly_i[i*c_TW +: c_TW];
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            sel       <= '0;
            sel_oh    <= '0;
            dly_o     <= '0;
            len_o     <= '0;
            ack_o     <= '0;
            busy_o    <= 1'b0;
            cur_dly_o <= '0;
        end else begin
            ack_o <= '0;
            case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        sel    <= arb_idx;
                        sel_oh <= arb_grant;
                        dly_o  <= arb_dly;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == 8'(g_SETUP_CYCLES - 1)) begin
                        cnt   <= '0;
                        len_o <= sel_oh;
                        state <= S_STROBE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_STROBE: begin
                    if (cnt == 8'(g_LEN_CYCLES - 1)) begin
                        cnt   <= '0;
                        len_o <= '0;
                        // dly_o is frozen since grant, so it is exactly what the chip latched
                        for (int i = 0; i < g_NUM_CHANNELS; i++)
                            if (sel_oh[i]) cur_dly_o[i*c_TW +: c_TW] <= dly_o;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt == 8'(g_HOLD_CYCLES - 1)) begin
                        cnt   <= '0;
                        ack_o <= sel_oh;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    rr_ptr <= (sel == c_IDX_W'(g_NUM_CHANNELS - 1)) ? '0 : sel + 4'd1;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fd_delay_line_loader.md
Name: fd_delay_line_loader

Overview:
- Sequences programming of the per-channel MC100EP195 programmable delay lines on the fine-delay card.
- All chips share one 10-bit tap bus (dly_o); each chip has its own latch-enable line (len_o[n]).
- Arbitrates round-robin between per-channel load requests from the channel timing logic.
- For each grant it drives the tap bus, waits setup, pulses the channel's LEN, waits hold, then acknowledges.

Parameters:
- g_NUM_CHANNELS, 8, number of delay-line chips / requesters (1..16).
- g_SETUP_CYCLES, 2, clk_sys_i cycles the tap bus is stable before LEN rises (1..255).
- g_LEN_CYCLES, 3, clk_sys_i cycles LEN is held high (1..255).
- g_HOLD_CYCLES, 2, clk_sys_i cycles the tap bus stays stable after LEN falls (1..255).

Ports:
- clk_sys_i  in  1  system clock; all logic is on its rising edge.
- rst_sys_i  in  1  synchronous, active-high reset.
- req_i  in  g_NUM_CHANNELS  per-channel load request, level; held until the matching ack.
- dly_i  in  10*g_NUM_CHANNELS  per-channel tap value; channel n occupies bits [10n+9:10n].
- ack_o  out  g_NUM_CHANNELS  one-cycle pulse on the channel just loaded.
- dly_o  out  10  shared tap bus to the delay-line chips.
- len_o  out  g_NUM_CHANNELS  per-chip latch enable; at most one bit is high at any time.
- busy_o  out  1  high in every state except IDLE.
- cur_dly_o  out  10*g_NUM_CHANNELS  shadow copy of the value last latched into each chip.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, dly_o=0, len_o=0, ack_o=0, busy_o=0, cur_dly_o=0, counter=0. Applied on the clock edge where rst_sys_i=1, including mid-sequence; len_o therefore drops at that edge.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - If any req_i bit is high, select the first set bit searching upward from rr_ptr, wrapping at g_NUM_CHANNELS.
  - Register the selected channel index as sel, load dly_o from that channel's dly_i slice, clear the counter, go to SETUP.
- SETUP: dly_o is held. After g_SETUP_CYCLES cycles, set len_o[sel]=1 and go to STROBE.
- STROBE: len_o[sel] is high for exactly g_LEN_CYCLES cycles. Then clear len_o, copy dly_o into the cur_dly_o slot for sel, go to HOLD.
- HOLD: dly_o is held. After g_HOLD_CYCLES cycles, go to DONE.
- DONE:
  - ack_o[sel] is high for this one cycle.
  - rr_ptr becomes sel+1, wrapping to 0 at g_NUM_CHANNELS.
  - Return to IDLE. The next grant can occur no earlier than the following cycle.
- Latency: from req_i sampled high in IDLE to ack_o = 1 + g_SETUP_CYCLES + g_LEN_CYCLES + g_HOLD_CYCLES cycles. With defaults this is 8.
- Value capture:
  - dly_i is sampled only at grant.
  - dly_o never changes between grant and DONE, because the LEN latch is transparent.
  - Later changes to dly_i need a new request.
- req_i rules:
  - A requester must hold req_i until its ack and drop it in the cycle after the ack.
  - A request still high in IDLE after its ack is treated as a new request and is reloaded.
  - If req_i drops while that channel is in service, the sequence still completes and acks.
- Arbitration: strict round-robin. With all requests asserted, channels are served 0,1,...,N-1,0,... Simultaneous requests never lose a grant.
- len_o: one-hot or zero. Never high during SETUP, HOLD, DONE or IDLE.
- Counter: 8 bits, compared against the parameter minus 1. A parameter value of 1 gives a one-cycle state.

Decomposition:
- Package fd_delay_line_pkg holds:
  - c_FD_TAP_WIDTH = 10;
  - the FSM state enum t_loader_state;
  - the function f_rr_select(req, ptr), which returns the index and a valid flag.
- One natural sub-module: fd_rr_arbiter. It is combinational: the request vector and pointer go in, a one-hot grant and binary index come out. The loader owns the pointer register.

Test Plan:
- Single load: req_i[2]=1, dly_i[2]=10'h155.
  - dly_o=0x155 one cycle after the grant edge.
  - len_o=8'b0000_0100 for 3 cycles, starting 2 cycles later.
  - ack_o[2] 8 cycles after the request.
  - cur_dly_o[2]=0x155.
- All-channel contention: req_i=8'hFF with distinct values 0x000..0x007.
  - Acks arrive in order 0..7, each 9 cycles apart.
  - Each LEN pulse coincides with that channel's value on dly_o.
- Round-robin fairness: after serving channel 5, assert req_i=8'b0010_0001.
  - Channel 0 is granted, not channel 5.
  - Repeat with rr_ptr=6: the grant wraps to 0 before 5.
- Bus stability: change dly_i[1] from 0x3FF to 0x001 during STROBE.
  - dly_o stays 0x3FF through HOLD.
  - cur_dly_o[1]=0x3FF.
- Reset mid-op: assert rst_sys_i on the 2nd STROBE cycle.
  - len_o=0, busy_o=0 and cur_dly_o=0 from the next edge.
  - No ack is issued.
  - A request still held after reset is re-served from state IDLE.
- Parameter corner: g_SETUP=g_LEN=g_HOLD=1.
  - Latency is 4 cycles.
  - len_o is high for exactly 1 cycle.
  - A persistent req_i[0] is reloaded every 5 cycles.
